// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and helpers for the 5x5 convolution window feeder.
//   - DEF_* : default geometry (pixel width, filter size, feature-map size)
//   - conv_state_t : one-hot frame-sequencing states
//   - win_lsb() : bit offset of a (row, col) tap inside the packed window bus
package conv_pkg;

  localparam int DEF_DATA_WIDTH    = 12;
  localparam int DEF_FILTER_WIDTH  = 5;
  localparam int DEF_FILTER_HEIGHT = 5;
  localparam int DEF_INPUT_WIDTH   = 32;
  localparam int DEF_INPUT_HEIGTH  = 32;

  typedef enum logic [2:0] {
    S_FILL   = 3'b001,
    S_STREAM = 3'b010,
    S_LAST   = 3'b100
  } conv_state_t;

  // Unit k = fr*fw + fc + 1 sits at [k*dw-1 -: dw], so unit 1 (oldest
  // row, oldest column) is at the LSBs.
  function automatic int win_lsb(input int fr, input int fc, input int fw, input int dw);
    return (fr * fw + fc) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one feature-map row of delay.
//   clk  : clock
//   en   : shift enable (one accepted pixel)
//   din  : pixel entering the row
//   dout : pixel that entered DEPTH accepts ago (same column, previous row)
// Contents are never reset; stale data is flushed before any window uses it.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_INPUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

  assign dout = sr[DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) sr <= {sr[DEPTH-2:0], din};
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-scan pixel stream in, every valid stride-1 5x5
// window out as a packed 25-unit bus (unit 1 = pixel (r-4,c-4), unit 25 =
// completing pixel (r,c), row-major), registered one cycle after the accept.
//   clk, rst_n            : clock, async active-low reset
//   pix_in/valid/ready    : pixel input handshake
//   win_out/valid/ready   : window output handshake (single register, no skid)
//   frame_done            : 1-cycle pulse after the last window of a frame is taken
//   win_count             : windows taken this frame (only with CONV_WIN_CNT_EN)
// Optional feature macro: CONV_WIN_CNT_EN.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FILTER_WIDTH  = DEF_FILTER_WIDTH,
  parameter int FILTER_HEIGHT = DEF_FILTER_HEIGHT,
  parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int INPUT_HEIGTH  = DEF_INPUT_HEIGTH,
  localparam int WIN_BITS     = FILTER_WIDTH * FILTER_HEIGHT * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic [WIN_BITS-1:0]          win_out,
  output logic                         win_valid,
  input  logic                         win_ready,
`ifdef CONV_WIN_CNT_EN
  output logic                         frame_done,
  output logic [$clog2((INPUT_WIDTH-FILTER_WIDTH+1)*(INPUT_HEIGTH-FILTER_HEIGHT+1)+1)-1:0] win_count
`else
  output logic                         frame_done
`endif
);

  localparam int CW = $clog2(INPUT_WIDTH);
  localparam int RW = $clog2(INPUT_HEIGTH);

  conv_state_t   state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          acc, hs, col_last, row_last, cmpl;

  // Output register is only overwritten when empty or being drained.
  assign pix_ready = !win_valid || win_ready;
  assign acc       = pix_valid && pix_ready;
  assign hs        = win_valid && win_ready;
  assign col_last  = (col == CW'(INPUT_WIDTH - 1));
  assign row_last  = (row == RW'(INPUT_HEIGTH - 1));
  assign cmpl      = acc && (row >= RW'(FILTER_HEIGHT - 1)) && (col >= CW'(FILTER_WIDTH - 1));

  // Line-buffer chain: lb_out[i] is pixel (r-1-i, c) while pixel (r, c) is on pix_in.
  logic [FILTER_HEIGHT-2:0][DATA_WIDTH-1:0] lb_out;
  // col_in[fr] is the new column entering window row fr (fr = FILTER_HEIGHT-1 newest).
  logic [FILTER_HEIGHT-1:0][DATA_WIDTH-1:0] col_in;

  assign col_in[FILTER_HEIGHT-1] = pix_in;

  for (genvar i = 0; i < FILTER_HEIGHT - 1; i++) begin : g_lb
    logic [DATA_WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign din = pix_in;
    end else begin : g_link
      assign din = lb_out[i-1];
    end
    conv_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(INPUT_WIDTH)) u_lb (
      .clk  (clk),
      .en   (acc),
      .din  (din),
      .dout (lb_out[i])
    );
    assign col_in[FILTER_HEIGHT-2-i] = lb_out[i];
  end

  // Only the newest FILTER_WIDTH-1 columns are kept; the window seen with
  // the completing pixel is those columns plus col_in.
  logic [FILTER_HEIGHT-1:0][FILTER_WIDTH-2:0][DATA_WIDTH-1:0] taps;
  logic [FILTER_HEIGHT-1:0][FILTER_WIDTH-1:0][DATA_WIDTH-1:0] nxt;
  logic [WIN_BITS-1:0]                                        win_nxt;

  for (genvar fr = 0; fr < FILTER_HEIGHT; fr++) begin : g_row
    for (genvar fc = 0; fc < FILTER_WIDTH; fc++) begin : g_col
      if (fc == FILTER_WIDTH - 1) begin : g_new
        assign nxt[fr][fc] = col_in[fr];
      end else begin : g_old
        assign nxt[fr][fc] = taps[fr][fc];
      end
      assign win_nxt[win_lsb(fr, fc, FILTER_WIDTH, DATA_WIDTH) +: DATA_WIDTH] = nxt[fr][fc];
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      for (int fr = 0; fr < FILTER_HEIGHT; fr++) taps[fr] <= nxt[fr][FILTER_WIDTH-1:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      state      <= S_FILL;
      win_valid  <= 1'b0;
      win_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (acc) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
      // A new window beats a simultaneous drain, so valid stays high.
      if (cmpl) begin
        win_out   <= win_nxt;
        win_valid <= 1'b1;
      end else if (hs) begin
        win_valid <= 1'b0;
      end
      unique case (state)
        S_FILL:   if (acc && col_last && row == RW'(FILTER_HEIGHT - 2)) state <= S_STREAM;
        S_STREAM: if (acc && col_last && row_last) state <= S_LAST;
        S_LAST: begin
          // Next-frame pixels may already be flowing; only the final
          // window's handshake ends the frame.
          if (hs) begin
            frame_done <= 1'b1;
            state      <= S_FILL;
          end
        end
        default:  state <= S_FILL;
      endcase
    end
  end

`ifdef CONV_WIN_CNT_EN
  // Holds the full-frame total during the frame_done cycle, then clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          win_count <= '0;
    else if (frame_done) win_count <= {{($bits(win_count)-1){1'b0}}, hs};
    else if (hs)         win_count <= win_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
  localparam int DW = 12, FW = 5, FH = 5, IW = 32, IH = 32;
  localparam int WB = FW * FH * DW;
  localparam int NWIN = (IW - FW + 1) * (IH - FH + 1);

  typedef logic [WB-1:0] wv_t;
  typedef struct { logic [WB-1:0] w; bit last; } win_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic signed [DW-1:0] pix_in = '0;
  logic pix_valid = 1'b0, win_ready = 1'b0;
  logic pix_ready, win_valid, frame_done;
  logic [WB-1:0] win_out;
`ifdef CONV_WIN_CNT_EN
  logic [9:0] win_count;
`endif

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
`ifdef CONV_WIN_CNT_EN
    .frame_done (frame_done),
    .win_count  (win_count)
`else
    .frame_done (frame_done)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame as a 2-D array; every accepted pixel that
  // lands at row>=4, col>=4 produces the 5x5 neighbourhood ending there.
  logic [DW-1:0] pm [IH][IW];
  win_t          wq[$];     // windows produced but not yet taken
  logic [WB-1:0] wlog[$];   // windows taken from the DUT, in order
  int            nacc;      // pixels accepted since reset
  bit            fd_exp;
  int            nfd, first_vld_acc;
  bit            ramp = 1'b1;

  function automatic int unit(input logic [WB-1:0] w, input int k);
    return int'(w[(k-1)*DW +: DW]);
  endfunction

  function automatic void accept(input logic [DW-1:0] p);
    int r, c;
    win_t e;
    r = (nacc % (IW * IH)) / IW;
    c = nacc % IW;
    pm[r][c] = p;
    if (r >= FH - 1 && c >= FW - 1) begin
      for (int k = 0; k < FW * FH; k++)
        e.w[k*DW +: DW] = pm[r - (FH-1) + k / FW][c - (FW-1) + k % FW];
      e.last = (r == IH - 1 && c == IW - 1);
      wq.push_back(e);
    end
    nacc++;
  endfunction

  task automatic step();
    bit exp_v, exp_r, acc, hs;
    @(negedge clk);
    exp_v = (wq.size() != 0);
    exp_r = !exp_v || win_ready;
    chk("win_valid", wv_t'(win_valid), wv_t'(exp_v));
    chk("pix_ready", wv_t'(pix_ready), wv_t'(exp_r));
    chk("frame_done", wv_t'(frame_done), wv_t'(fd_exp));
    if (exp_v) chk("win_out", win_out, wq[0].w);
`ifdef CONV_WIN_CNT_EN
    if (fd_exp) chk("win_count", wv_t'(win_count), wv_t'(NWIN));
`endif
    if (frame_done) nfd++;
    if (win_valid && first_vld_acc < 0) first_vld_acc = nacc;
    acc = pix_valid && exp_r;
    hs  = exp_v && win_ready;
    fd_exp = 1'b0;
    if (hs) begin
      wlog.push_back(win_out);
      fd_exp = wq[0].last;
      wq.delete(0);
    end
    if (acc) accept(pix_in);
    @(posedge clk);
    #1;
  endtask

  task automatic new_scn();
    wlog.delete();
    nfd = 0;
    first_vld_acc = -1;
  endtask

  task automatic run(input int npix, input int vpct, input int rpct, input bit stall, input bit drain);
    int sent0, cyc, stall_cnt, acc_at_stall;
    bit stall_pend;
    sent0 = nacc; cyc = 0; stall_cnt = 0; acc_at_stall = -1; stall_pend = stall;
    while (nacc - sent0 < npix && cyc < npix * 8 + 200) begin
      if (stall_pend && wq.size() != 0) begin
        stall_pend = 1'b0;
        stall_cnt = 10;
        acc_at_stall = nacc;
      end
      pix_valid = ($urandom_range(99) < vpct);
      pix_in    = ramp ? DW'(nacc % (IW * IH)) : DW'($urandom);
      win_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(99) < rpct);
      step();
      cyc++;
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) chk("stall_no_accept", wv_t'(nacc), wv_t'(acc_at_stall));
      end
    end
    chk("pix_timeout", wv_t'(nacc - sent0), wv_t'(npix));
    if (drain) begin
      pix_valid = 1'b0;
      win_ready = 1'b1;
      cyc = 0;
      while ((wq.size() != 0 || fd_exp) && cyc < 20) begin
        step();
        cyc++;
      end
      chk("drain_timeout", wv_t'(wq.size()), wv_t'(0));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    chk("rst_win_valid", wv_t'(win_valid), wv_t'(0));
    chk("rst_frame_done", wv_t'(frame_done), wv_t'(0));
    chk("rst_win_out", win_out, wv_t'(0));
    chk("rst_pix_ready", wv_t'(pix_ready), wv_t'(1));
    wq.delete();
    nacc = 0;
    fd_exp = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_ramp();
    chk("first_latency", wv_t'(first_vld_acc), wv_t'(133));
    chk("num_windows", wv_t'(wlog.size()), wv_t'(NWIN));
    chk("num_frame_done", wv_t'(nfd), wv_t'(1));
    if (wlog.size() == NWIN) begin
      chk("first_u1", wv_t'(unit(wlog[0], 1)), wv_t'(0));
      chk("first_u13", wv_t'(unit(wlog[0], 13)), wv_t'(66));
      chk("first_u25", wv_t'(unit(wlog[0], 25)), wv_t'(132));
      chk("row4_last_u25", wv_t'(unit(wlog[27], 25)), wv_t'(159));
      chk("row5_first_u25", wv_t'(unit(wlog[28], 25)), wv_t'(164));
      chk("last_u1", wv_t'(unit(wlog[NWIN-1], 1)), wv_t'(891));
      chk("last_u25", wv_t'(unit(wlog[NWIN-1], 25)), wv_t'(1023));
    end
  endtask

  initial begin
    #2;
    do_reset();

    // Ramp, no gaps, always ready.
    new_scn(); ramp = 1'b1;
    run(IW * IH, 100, 100, 1'b0, 1'b1);
    check_ramp();

    // Backpressure for 10 cycles on the first window.
    new_scn();
    run(IW * IH, 100, 100, 1'b1, 1'b1);
    chk("stall_num_windows", wv_t'(wlog.size()), wv_t'(NWIN));
    chk("stall_num_fd", wv_t'(nfd), wv_t'(1));
    if (wlog.size() >= 2) begin
      chk("stall_w0_u25", wv_t'(unit(wlog[0], 25)), wv_t'(132));
      chk("stall_w1_u25", wv_t'(unit(wlog[1], 25)), wv_t'(133));
    end

    // Two frames back-to-back, random gaps on both sides.
    new_scn();
    run(2 * IW * IH, 60, 70, 1'b0, 1'b1);
    chk("two_num_windows", wv_t'(wlog.size()), wv_t'(2 * NWIN));
    chk("two_num_fd", wv_t'(nfd), wv_t'(2));
    if (wlog.size() > NWIN) begin
      chk("two_repeat_first", wlog[NWIN], wlog[0]);
      chk("two_second_u25", wv_t'(unit(wlog[NWIN], 25)), wv_t'(132));
    end

    // Random pixel data (including negative values).
    new_scn(); ramp = 1'b0;
    run(IW * IH, 80, 80, 1'b0, 1'b1);
    chk("rand_num_windows", wv_t'(wlog.size()), wv_t'(NWIN));
    chk("rand_num_fd", wv_t'(nfd), wv_t'(1));

    // Reset mid-frame at pixel 500, then a fresh ramp.
    new_scn(); ramp = 1'b1;
    run(500, 100, 100, 1'b0, 1'b0);
    do_reset();
    new_scn();
    run(IW * IH, 100, 100, 1'b0, 1'b1);
    check_ramp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
